// File: rtl/fc_arb_pkg.sv
// Shared types and width helpers for the FC L2 port arbiter.
package fc_arb_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    // Index width for a requester count; a single requester still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Occupancy counter width, wide enough to hold the full depth itself.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fc_arb_id_fifo.sv
// Synchronous FIFO of requester indices for in-order response routing.
// DEPTH must be a power of two (at least 2) so the pointers wrap naturally.
module fc_arb_id_fifo
    import fc_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem[rd_ptr_q];

    // A push into a full FIFO is accepted only when a pop frees the slot that cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fc_l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 TCDM master port among NB_REQ requesters,
// with in-order response routing through an ID FIFO.
module fc_l2_port_arbiter
    import fc_arb_pkg::*;
#(
    parameter int unsigned NB_REQ  = 2,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 36
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NB_REQ-1:0]    req_i,
    input  logic [NB_REQ*AW-1:0] add_i,
    input  logic [NB_REQ-1:0]    wen_i,
    input  logic [NB_REQ*DW-1:0] wdata_i,
    input  logic [NB_REQ*4-1:0]  be_i,
    output logic [NB_REQ-1:0]    gnt_o,
    output logic [NB_REQ-1:0]    r_valid_o,
    output logic [DW-1:0]        r_rdata_o,
    output logic                 r_opc_o,
    output logic                 l2_req_o,
    output logic [AW-1:0]        l2_add_o,
    output logic                 l2_wen_o,
    output logic [DW-1:0]        l2_wdata_o,
    output logic [3:0]           l2_be_o,
    input  logic                 l2_gnt_i,
    input  logic                 l2_r_valid_i,
    input  logic [DW-1:0]        l2_r_rdata_i,
    input  logic                 l2_r_opc_i,
    output logic                 unexp_rsp_o
);

    localparam int unsigned IDX_W = idx_w(NB_REQ);

    arb_state_e       state_q;
    logic [IDX_W-1:0] sel_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic             unexp_q;

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             eligible;
    logic             handshake;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [IDX_W-1:0] fifo_head;

    // Locked: keep the stalled winner. Idle: first request at or after rr_ptr.
    always_comb begin
        winner = rr_ptr_q;
        cand   = '0;
        found  = 1'b0;
        if (state_q == LOCKED) begin
            winner = sel_q;
        end else begin
            for (int unsigned i = 0; i < NB_REQ; i++) begin
                cand = IDX_W'((32'(rr_ptr_q) + i) % NB_REQ);
                if (!found && req_i[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    assign fifo_pop  = ~rst_i & l2_r_valid_i & ~fifo_empty;
    assign eligible  = ~fifo_full | fifo_pop;
    assign l2_req_o  = ~rst_i & eligible & req_i[winner];
    assign handshake = l2_req_o & l2_gnt_i;

    always_comb begin
        gnt_o      = '0;
        l2_add_o   = '0;
        l2_wen_o   = 1'b0;
        l2_wdata_o = '0;
        l2_be_o    = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            if (IDX_W'(i) == winner) begin
                gnt_o[i]   = handshake;
                l2_add_o   = add_i[i*AW +: AW];
                l2_wen_o   = wen_i[i];
                l2_wdata_o = wdata_i[i*DW +: DW];
                l2_be_o    = be_i[i*4 +: 4];
            end
        end
    end

    always_comb begin
        r_valid_o            = '0;
        r_valid_o[fifo_head] = fifo_pop;
    end

    assign r_rdata_o   = l2_r_rdata_i;
    assign r_opc_o     = l2_r_opc_i;
    assign unexp_rsp_o = unexp_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            unexp_q  <= 1'b0;
        end else begin
            if (l2_r_valid_i && fifo_empty) begin
                unexp_q <= 1'b1;
            end
            if (handshake) begin
                rr_ptr_q <= (winner == IDX_W'(NB_REQ - 1)) ? '0 : winner + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (l2_req_o && !l2_gnt_i) begin
                        state_q <= LOCKED;
                        sel_q   <= winner;
                    end
                end
                LOCKED: begin
                    // A dropped request abandons the lock without a push.
                    if (!l2_req_o || l2_gnt_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fc_arb_id_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .pop_i   (fifo_pop),
        .data_i  (winner),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Self-checking bench for fc_l2_port_arbiter against a queue-based reference model.
module tb_fc_l2_port_arbiter;

    localparam int NB      = 2;
    localparam int MAX_OUT = 4;
    localparam int AW      = 32;
    localparam int DW      = 36;

    logic           clk = 1'b0;
    logic           rst;
    logic [NB-1:0]  req;
    logic [AW-1:0]  add_a   [NB];
    logic           wen_a   [NB];
    logic [DW-1:0]  wdata_a [NB];
    logic [3:0]     be_a    [NB];
    logic           l2_gnt;
    logic           l2_r_valid;
    logic [DW-1:0]  l2_r_rdata;
    logic           l2_r_opc;

    logic [NB*AW-1:0] add;
    logic [NB-1:0]    wen;
    logic [NB*DW-1:0] wdata;
    logic [NB*4-1:0]  be;

    logic [NB-1:0] gnt_o;
    logic [NB-1:0] r_valid_o;
    logic [DW-1:0] r_rdata_o;
    logic          r_opc_o;
    logic          l2_req_o;
    logic [AW-1:0] l2_add_o;
    logic          l2_wen_o;
    logic [DW-1:0] l2_wdata_o;
    logic [3:0]    l2_be_o;
    logic          unexp_rsp_o;

    assign add   = {add_a[1], add_a[0]};
    assign wen   = {wen_a[1], wen_a[0]};
    assign wdata = {wdata_a[1], wdata_a[0]};
    assign be    = {be_a[1], be_a[0]};

    always #5 clk = ~clk;

    fc_l2_port_arbiter #(
        .NB_REQ  (NB),
        .MAX_OUT (MAX_OUT),
        .AW      (AW),
        .DW      (DW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .add_i        (add),
        .wen_i        (wen),
        .wdata_i      (wdata),
        .be_i         (be),
        .gnt_o        (gnt_o),
        .r_valid_o    (r_valid_o),
        .r_rdata_o    (r_rdata_o),
        .r_opc_o      (r_opc_o),
        .l2_req_o     (l2_req_o),
        .l2_add_o     (l2_add_o),
        .l2_wen_o     (l2_wen_o),
        .l2_wdata_o   (l2_wdata_o),
        .l2_be_o      (l2_be_o),
        .l2_gnt_i     (l2_gnt),
        .l2_r_valid_i (l2_r_valid),
        .l2_r_rdata_i (l2_r_rdata),
        .l2_r_opc_i   (l2_r_opc),
        .unexp_rsp_o  (unexp_rsp_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: outstanding requester IDs in issue order plus arbitration memory.
    int q [$];
    int m_rr     = 0;
    int m_sel    = 0;
    bit m_locked = 1'b0;
    bit m_unexp  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        int          win;
        bit          pop;
        bit          elig;
        bit          ereq;
        logic [1:0]  egnt;
        logic [1:0]  erv;
        @(negedge clk);
        pop  = !rst && l2_r_valid && (q.size() > 0);
        elig = (q.size() < MAX_OUT) || pop;
        win  = -1;
        if (m_locked) begin
            win = m_sel;
        end else begin
            for (int k = 0; k < NB; k++) begin
                int c;
                c = (m_rr + k) % NB;
                if (win < 0 && req[c]) win = c;
            end
        end
        ereq = !rst && (win >= 0) && req[win] && elig;
        egnt = (ereq && l2_gnt) ? 2'(1 << win) : 2'b00;
        erv  = pop ? 2'(1 << q[0]) : 2'b00;
        chk("l2_req", 64'(l2_req_o), 64'(ereq));
        chk("gnt", 64'(gnt_o), 64'(egnt));
        chk("r_valid", 64'(r_valid_o), 64'(erv));
        chk("unexp_rsp", 64'(unexp_rsp_o), 64'(m_unexp));
        if (pop) begin
            chk("r_rdata", 64'(r_rdata_o), 64'(l2_r_rdata));
            chk("r_opc", 64'(r_opc_o), 64'(l2_r_opc));
        end
        if (ereq) begin
            chk("l2_add", 64'(l2_add_o), 64'(add_a[win]));
            chk("l2_wen", 64'(l2_wen_o), 64'(wen_a[win]));
            chk("l2_wdata", 64'(l2_wdata_o), 64'(wdata_a[win]));
            chk("l2_be", 64'(l2_be_o), 64'(be_a[win]));
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_rr     = 0;
            m_sel    = 0;
            m_locked = 1'b0;
            m_unexp  = 1'b0;
        end else begin
            if (l2_r_valid && q.size() == 0) m_unexp = 1'b1;
            if (pop) void'(q.pop_front());
            if (ereq && l2_gnt) begin
                q.push_back(win);
                m_rr     = (win + 1) % NB;
                m_locked = 1'b0;
            end else if (ereq) begin
                m_locked = 1'b1;
                m_sel    = win;
            end else begin
                m_locked = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic g, input logic rv,
                         input logic [DW-1:0] rd, input logic op);
        req        = r;
        l2_gnt     = g;
        l2_r_valid = rv;
        l2_r_rdata = rd;
        l2_r_opc   = op;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NB; i++) begin
            add_a[i]   = 32'h1000 * (i + 1);
            wen_a[i]   = 1'b1;
            wdata_a[i] = 36'h0;
            be_a[i]    = 4'hF;
        end
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);

        // Reset state
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Single read from requester 0, response three cycles later
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        cycle();
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        cycle();
        cycle();
        drive(2'b00, 1'b0, 1'b1, 36'hA_DEADBEEF, 1'b0);
        cycle();
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        cycle();

        // Both requesting, grant every cycle: strict alternation
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
        repeat (4) cycle();
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 1'b0, 1'b1, 36'(i + 36'h100), 1'b0);
            cycle();
        end

        // Requester 1 stalls without grant; requester 0 must not steal the port
        drive(2'b10, 1'b0, 1'b0, '0, 1'b0);
        cycle();
        drive(2'b11, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            add_a[0] = 32'hBAD0_0000 + 32'(i);
            cycle();
        end
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
        chk("locked_add_stable", 64'(l2_add_o), 64'(32'h2000));
        cycle();
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        cycle();
        drive(2'b00, 1'b0, 1'b1, 36'h5_55555555, 1'b0);
        cycle();

        // Fill all MAX_OUT slots; 5th request held until a response pops
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        repeat (MAX_OUT) cycle();
        cycle();
        chk("full_holds_req", 64'(l2_req_o), 64'd0);
        drive(2'b01, 1'b1, 1'b1, 36'h7_77777777, 1'b0);
        cycle();
        drive(2'b00, 1'b0, 1'b1, 36'h8_88888888, 1'b0);
        repeat (MAX_OUT) cycle();

        // Interleaved 0,1,1,0 then four responses, error on the third
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        cycle();
        drive(2'b10, 1'b1, 1'b0, '0, 1'b0);
        cycle();
        cycle();
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 1'b0, 1'b1, 36'(36'hC_00000000 + i), (i == 2));
            if (i == 2) begin
                #0;
                chk("third_rsp_to_req1", 64'(r_valid_o), 64'b10);
            end
            cycle();
        end

        // Reset with two outstanding, then a stray response
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
        cycle();
        cycle();
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(2'b00, 1'b0, 1'b1, 36'hF_FFFFFFFF, 1'b1);
        cycle();
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        cycle();
        cycle();
        chk("unexp_sticky", 64'(unexp_rsp_o), 64'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("unexp_cleared", 64'(unexp_rsp_o), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NB; i++) begin
                add_a[i]   = $urandom;
                wen_a[i]   = 1'($urandom_range(0, 1));
                wdata_a[i] = {4'($urandom_range(0, 15)), 32'($urandom)};
                be_a[i]    = 4'($urandom_range(0, 15));
            end
            drive(2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0),
                  (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0),
                  {4'($urandom_range(0, 15)), 32'($urandom)},
                  1'($urandom_range(0, 1)));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
